// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use / flag-hazard bubbles, post-branch fetch squash,
// memory-busy freeze and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned REDIRECT_LAT = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Aa,
    input  logic [4:0]       Ab,
    input  logic             useA,
    input  logic             useB,
    input  logic             cbranchID,
    input  logic [4:0]       AwEX,
    input  logic             regwriteEX,
    input  logic             memreadEX,
    input  logic             setflagsEX,
    input  logic             brTakenEX,
    input  logic             memBusy,
    output logic             pcWrite,
    output logic             pcSel,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             pipeWrite,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned     FCNT_W   = 4;
    localparam logic [FCNT_W-1:0] LAT_INIT = FCNT_W'(REDIRECT_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               load_use, flag_haz, hazard;
    logic               stall_inc;

    // Hazards forwarding cannot cover; X31 is the zero register and never conflicts.
    always_comb begin
        load_use = memreadEX & regwriteEX & (AwEX != 5'd31) &
                   ((useA & (Aa == AwEX)) | (useB & (Ab == AwEX)));
        flag_haz = cbranchID & setflagsEX;
        hazard   = load_use | flag_haz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (stall_inc && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
            if (ifidFlush && flush_q != CNT_MAX) flush_q <= flush_q + 1'b1;
        end
    end

    // Priority: freeze > taken branch > flush window > hazard bubble > run.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pcWrite   = 1'b1;
        pcSel     = 1'b0;
        ifidWrite = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        pipeWrite = 1'b1;
        stall_inc = 1'b0;

        if (reset) begin
            state_d = RUN;
        end else if (memBusy) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            pipeWrite = 1'b0;
        end else if (brTakenEX) begin
            pcSel     = 1'b1;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            if (REDIRECT_LAT != 0) begin
                state_d = FLUSH;
                fcnt_d  = LAT_INIT;
            end
        end else if (state_q == FLUSH) begin
            ifidFlush = 1'b1;
            fcnt_d    = fcnt_q - 1'b1;
            if (fcnt_q <= FCNT_W'(1)) begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        end else if (hazard) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            stall_inc = 1'b1;
        end
    end

    assign stallCount = stall_q;
    assign flushCount = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LAT=1/CNT_W=16 and LAT=2/CNT_W=2)
// share stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] Aa = '0, Ab = '0, AwEX = '0;
    logic useA = 0, useB = 0, cbranchID = 0, regwriteEX = 0, memreadEX = 0;
    logic setflagsEX = 0, brTakenEX = 0, memBusy = 0;

    logic pcWrite_a, pcSel_a, ifidWrite_a, ifidFlush_a, idexFlush_a, pipeWrite_a;
    logic pcWrite_b, pcSel_b, ifidWrite_b, ifidFlush_b, idexFlush_b, pipeWrite_b;
    logic [15:0] stall_a, flush_a;
    logic [1:0]  stall_b, flush_b;
    logic [5:0]  ctl_a, ctl_b;

    localparam int LAT_A = 1, W_A = 16, LAT_B = 2, W_B = 2;
    localparam int K_RST = 0, K_FRZ = 1, K_BR = 2, K_FL = 3, K_STL = 4, K_RUN = 5;

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_LAT(LAT_A), .CNT_W(W_A)) u_a (
        .clk(clk), .reset(reset), .Aa(Aa), .Ab(Ab), .useA(useA), .useB(useB),
        .cbranchID(cbranchID), .AwEX(AwEX), .regwriteEX(regwriteEX), .memreadEX(memreadEX),
        .setflagsEX(setflagsEX), .brTakenEX(brTakenEX), .memBusy(memBusy),
        .pcWrite(pcWrite_a), .pcSel(pcSel_a), .ifidWrite(ifidWrite_a), .ifidFlush(ifidFlush_a),
        .idexFlush(idexFlush_a), .pipeWrite(pipeWrite_a), .stallCount(stall_a), .flushCount(flush_a));

    hazard_ctrl #(.REDIRECT_LAT(LAT_B), .CNT_W(W_B)) u_b (
        .clk(clk), .reset(reset), .Aa(Aa), .Ab(Ab), .useA(useA), .useB(useB),
        .cbranchID(cbranchID), .AwEX(AwEX), .regwriteEX(regwriteEX), .memreadEX(memreadEX),
        .setflagsEX(setflagsEX), .brTakenEX(brTakenEX), .memBusy(memBusy),
        .pcWrite(pcWrite_b), .pcSel(pcSel_b), .ifidWrite(ifidWrite_b), .ifidFlush(ifidFlush_b),
        .idexFlush(idexFlush_b), .pipeWrite(pipeWrite_b), .stallCount(stall_b), .flushCount(flush_b));

    // Control bundle order: {pcWrite, pcSel, ifidWrite, ifidFlush, idexFlush, pipeWrite}
    assign ctl_a = {pcWrite_a, pcSel_a, ifidWrite_a, ifidFlush_a, idexFlush_a, pipeWrite_a};
    assign ctl_b = {pcWrite_b, pcSel_b, ifidWrite_b, ifidFlush_b, idexFlush_b, pipeWrite_b};

    int n_cmp = 0, n_bad = 0;
    // Model state: remaining flush cycles, and the two event counts
    int fl_a = 0, st_a = 0, fc_a = 0, fl_b = 0, st_b = 0, fc_b = 0;
    int kind_a, kind_b;
    logic [5:0] exp_a, exp_b;

    function automatic bit hazard_ref();
        bit lu;
        lu = memreadEX && regwriteEX && AwEX != 5'd31 &&
             ((useA && Aa == AwEX) || (useB && Ab == AwEX));
        return lu || (cbranchID && setflagsEX);
    endfunction

    function automatic int classify(input int fl);
        if (reset)      return K_RST;
        if (memBusy)    return K_FRZ;
        if (brTakenEX)  return K_BR;
        if (fl > 0)     return K_FL;
        if (hazard_ref()) return K_STL;
        return K_RUN;
    endfunction

    function automatic logic [5:0] ctl_of(input int k);
        case (k)
            K_FRZ:   return 6'b000000;
            K_BR:    return 6'b111111;
            K_FL:    return 6'b101101;
            K_STL:   return 6'b000011;
            default: return 6'b101001;
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    task automatic adv(input int k, input int lat, input int w, inout int fl, inout int st, inout int fc);
        case (k)
            K_RST: begin fl = 0; st = 0; fc = 0; end
            K_BR:  begin fl = lat; fc = sat_inc(fc, w); end
            K_FL:  begin fl = fl - 1; fc = sat_inc(fc, w); end
            K_STL: st = sat_inc(st, w);
            default: ;
        endcase
    endtask

    task automatic settle();
        #1;
        kind_a = classify(fl_a);
        kind_b = classify(fl_b);
        exp_a  = ctl_of(kind_a);
        exp_b  = ctl_of(kind_b);
    endtask

    task automatic tick();
        adv(kind_a, LAT_A, W_A, fl_a, st_a, fc_a);
        adv(kind_b, LAT_B, W_B, fl_b, st_b, fc_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {useA, useB, cbranchID, regwriteEX, memreadEX, setflagsEX, brTakenEX, memBusy} = '0;
        Aa = 5'd0; Ab = 5'd0; AwEX = 5'd0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        memreadEX = 1; regwriteEX = 1; AwEX = r; Aa = r; useA = 1;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL reset_ctl got %b want %b", ctl_a, exp_a); end
        tick(); settle();
        n_cmp++; if (stall_a !== 16'd0 || flush_a !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_a, flush_a); end
        n_cmp++; if (stall_b !== 2'd0 || flush_b !== 2'd0) begin n_bad++; $display("FAIL reset_cnt_b got %0d/%0d want 0/0", stall_b, flush_b); end
        tick(); reset = 0;
    endtask

    task automatic test_load_use();
        idle_inputs(); set_load_use(5'd5); settle();
        n_cmp++; if (ctl_a !== 6'b000011) begin n_bad++; $display("FAIL load_use_ctl got %b want %b", ctl_a, 6'b000011); end
        tick(); idle_inputs(); settle();
        n_cmp++; if (stall_a !== 16'd1) begin n_bad++; $display("FAIL load_use_cnt got %0d want 1", stall_a); end
        set_load_use(5'd31); settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL x31_no_stall got %b want %b", ctl_a, exp_a); end
        tick();
        idle_inputs(); memreadEX = 1; regwriteEX = 1; AwEX = 5'd9; Ab = 5'd9; useB = 1; Aa = 5'd9; settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL load_use_b got %b want %b", ctl_a, exp_a); end
        tick(); idle_inputs(); settle();
        n_cmp++; if (stall_a !== 16'(st_a)) begin n_bad++; $display("FAIL load_use_cnt2 got %0d want %0d", stall_a, st_a); end
    endtask

    task automatic test_flag();
        idle_inputs(); cbranchID = 1; setflagsEX = 1; settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL flag_haz got %b want %b", ctl_a, exp_a); end
        tick(); setflagsEX = 0; settle();
        n_cmp++; if (pcWrite_a !== 1'b1 || ctl_a !== exp_a) begin n_bad++; $display("FAIL flag_nohaz got %b want %b", ctl_a, exp_a); end
        tick();
    endtask

    task automatic test_branch();
        int base;
        idle_inputs(); base = fc_a; brTakenEX = 1; settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL br_t got %b want %b", ctl_a, exp_a); end
        tick(); idle_inputs(); settle();
        n_cmp++; if (ctl_a !== exp_a) begin n_bad++; $display("FAIL br_t1 got %b want %b", ctl_a, exp_a); end
        tick(); settle();
        n_cmp++; if (ctl_a !== 6'b101001) begin n_bad++; $display("FAIL br_t2 got %b want %b", ctl_a, 6'b101001); end
        n_cmp++; if (flush_a !== 16'(base + 2)) begin n_bad++; $display("FAIL br_fcnt got %0d want %0d", flush_a, base + 2); end
        tick();
    endtask

    task automatic test_freeze();
        idle_inputs(); brTakenEX = 1; settle(); tick();
        idle_inputs(); memBusy = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (ctl_b !== 6'b000000) begin n_bad++; $display("FAIL freeze_%0d got %b want 000000", i, ctl_b); end
            tick();
        end
        memBusy = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (ctl_b !== exp_b || ctl_a !== exp_a) begin n_bad++; $display("FAIL post_freeze_%0d got %b/%b want %b/%b", i, ctl_a, ctl_b, exp_a, exp_b); end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int base;
        idle_inputs(); base = st_a; set_load_use(5'd7); brTakenEX = 1; settle();
        n_cmp++; if (ctl_a !== 6'b111111) begin n_bad++; $display("FAIL simul_ctl got %b want 111111", ctl_a); end
        tick(); idle_inputs(); settle();
        n_cmp++; if (stall_a !== 16'(base)) begin n_bad++; $display("FAIL simul_stall got %0d want %0d", stall_a, base); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_in_flush();
        idle_inputs(); brTakenEX = 1; settle(); tick();
        idle_inputs(); reset = 1; settle();
        n_cmp++; if (ctl_b !== exp_b) begin n_bad++; $display("FAIL rst_flush_ctl got %b want %b", ctl_b, exp_b); end
        tick(); reset = 0; settle();
        n_cmp++; if (ifidFlush_b !== 1'b0 || ctl_b !== exp_b) begin n_bad++; $display("FAIL rst_flush_run got %b want %b", ctl_b, exp_b); end
        n_cmp++; if (flush_b !== 2'd0 || stall_a !== 16'd0) begin n_bad++; $display("FAIL rst_flush_cnt got %0d/%0d want 0/0", flush_b, stall_a); end
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs(); set_load_use(5'd3);
        for (int i = 0; i < 5; i++) begin settle(); tick(); end
        idle_inputs(); settle();
        n_cmp++; if (stall_b !== 2'd3) begin n_bad++; $display("FAIL sat_b got %0d want 3", stall_b); end
        n_cmp++; if (stall_a !== 16'd5) begin n_bad++; $display("FAIL sat_a got %0d want 5", stall_a); end
        tick(); set_load_use(5'd3); settle(); tick(); idle_inputs(); settle();
        n_cmp++; if (stall_b !== 2'd3) begin n_bad++; $display("FAIL sat_hold got %0d want 3", stall_b); end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] regs [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            memBusy    = ($urandom_range(0, 99) < 15);
            brTakenEX  = ($urandom_range(0, 99) < 10);
            Aa         = regs[$urandom_range(0, 4)];
            Ab         = regs[$urandom_range(0, 4)];
            AwEX       = regs[$urandom_range(0, 4)];
            useA       = 1'($urandom_range(0, 1));
            useB       = 1'($urandom_range(0, 1));
            memreadEX  = 1'($urandom_range(0, 1));
            regwriteEX = 1'($urandom_range(0, 1));
            cbranchID  = ($urandom_range(0, 99) < 20);
            setflagsEX = 1'($urandom_range(0, 1));
            settle();
            n_cmp++; if (ctl_a !== exp_a || ctl_b !== exp_b) begin n_bad++; $display("FAIL rnd_ctl_%0d got %b/%b want %b/%b", i, ctl_a, ctl_b, exp_a, exp_b); end
            n_cmp++; if (stall_a !== 16'(st_a) || flush_a !== 16'(fc_a)) begin n_bad++; $display("FAIL rnd_cnt_a_%0d got %0d/%0d want %0d/%0d", i, stall_a, flush_a, st_a, fc_a); end
            n_cmp++; if (stall_b !== 2'(st_b) || flush_b !== 2'(fc_b)) begin n_bad++; $display("FAIL rnd_cnt_b_%0d got %0d/%0d want %0d/%0d", i, stall_b, flush_b, st_b, fc_b); end
            tick();
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_flag();
        test_branch();
        test_freeze();
        test_simultaneous();
        test_reset_in_flush();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
